// File: rtl/instr_fetch_unit.sv
`default_nettype none
// instr_fetch_unit: fetches one instruction per accepted PC over a req/gnt/rvalid bus
// and queues {pc, word} pairs in a first-word-fall-through FIFO for decode.
module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              discard_q, discard_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // Only one read is ever outstanding, so count<DEPTH at accept time leaves room for its response.
  assign pc_ready    = (state_q == IDLE) && !flush && (count_q < FULL_CNT);
  assign accept      = pc_valid && pc_ready;
  assign push        = (state_q == WAIT) && mem_rvalid && !discard_q && !flush;
  assign pop         = instr_valid && instr_ready;

  assign mem_req     = (state_q == REQ);
  assign mem_addr    = addr_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_mem[rptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rptr_q]   : '0;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d    = pc_in;
          discard_d = 1'b0;
          state_d   = REQ;
        end
      end
      REQ: begin
        // The request must stay up until granted; a flush only marks the response as stale.
        if (flush) discard_d = 1'b1;
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (flush) discard_d = 1'b1;
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (flush) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      discard_q <= 1'b0;
      count_q   <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wptr_q] <= mem_rdata;
      pc_mem[wptr_q]   <= addr_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit: directed stimulus against a queue-based reference model,
// checked every cycle, plus literal expectations for the key scenarios.
module tb_instr_fetch_unit;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pc_valid, flush, instr_ready;
  logic [AW-1:0] pc_in;
  logic          pc_ready, mem_req, instr_valid;
  logic [AW-1:0] mem_addr, instr_pc;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata, instr;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_valid    (pc_valid),
    .pc_in       (pc_in),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: word = addr + 0x1000 unless overridden in mem_tab.
  logic [DW-1:0] mem_tab [logic [AW-1:0]];
  function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
    if (mem_tab.exists(a)) return mem_tab[a];
    return a + 16'h1000;
  endfunction

  int            gnt_delay = 0;
  int            rsp_delay = 0;
  logic          stray = 1'b0;
  int            req_cnt = 0;
  int            rsp_cnt = 0;
  logic          rsp_pending = 1'b0;
  logic [AW-1:0] rsp_addr = '0;

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  end

  always begin
    @(posedge clock);
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (reset) begin
      req_cnt     = 0;
      rsp_pending = 1'b0;
    end else begin
      if (stray) begin
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
      end
      if (rsp_pending) begin
        if (rsp_cnt == rsp_delay) begin
          mem_rvalid  = 1'b1;
          mem_rdata   = memword(rsp_addr);
          rsp_pending = 1'b0;
        end else rsp_cnt++;
      end else if (mem_req) begin
        if (req_cnt == gnt_delay) begin
          mem_gnt     = 1'b1;
          req_cnt     = 0;
          rsp_pending = 1'b1;
          rsp_cnt     = 0;
          rsp_addr    = mem_addr;
        end else req_cnt++;
      end
    end
  end

  // Reference model: a queue of {pc, word} plus a single outstanding-read record.
  logic [31:0]   mq[$];
  logic          m_busy = 1'b0, m_granted = 1'b0, m_drop = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic          m_rdy, m_pop, m_push;

  always begin
    @(posedge clock or posedge reset);
    if (reset) begin
      mq.delete();
      m_busy = 1'b0; m_granted = 1'b0; m_drop = 1'b0; m_addr = '0;
    end else begin
      m_rdy  = !m_busy && !flush && (mq.size() < DEPTH);
      m_pop  = (mq.size() != 0) && instr_ready;
      m_push = 1'b0;
      if (m_busy && !m_granted) begin
        if (flush)   m_drop = 1'b1;
        if (mem_gnt) m_granted = 1'b1;
      end else if (m_busy) begin
        if (flush) m_drop = 1'b1;
        if (mem_rvalid) begin
          m_push    = !m_drop && !flush;
          m_busy    = 1'b0;
          m_granted = 1'b0;
        end
      end else if (pc_valid && m_rdy) begin
        m_busy = 1'b1;
        m_addr = pc_in;
        m_drop = 1'b0;
      end
      if (flush) mq.delete();
      else begin
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back({m_addr, mem_rdata});
      end
    end
  end

  logic          chk_en = 1'b0;
  logic [DW-1:0] log_q[$];
  logic          seen_dead = 1'b0;
  logic [31:0]   m_head;

  always begin
    @(negedge clock);
    if (chk_en) begin
      m_head = (mq.size() != 0) ? mq[0] : 32'h0;
      chk("pc_ready", 32'(pc_ready), 32'(!m_busy && !flush && (mq.size() < DEPTH)));
      chk("mem_req", 32'(mem_req), 32'(m_busy && !m_granted));
      if (m_busy && !m_granted) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
      chk("instr", 32'(instr), 32'(m_head[15:0]));
      chk("instr_pc", 32'(instr_pc), 32'(m_head[31:16]));
      if (instr_valid && instr_ready) log_q.push_back(instr);
      if (instr_valid && instr == 16'hDEAD) seen_dead = 1'b1;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Holds pc_valid until the PC is taken; returns 2 time units after the accepting edge.
  task automatic offer(input logic [AW-1:0] pc, input int budget);
    int n;
    n = 0;
    pc_valid = 1'b1;
    pc_in    = pc;
    #1;
    while (!pc_ready && n < budget) begin
      step();
      #1;
      n++;
    end
    if (!pc_ready) chk("offer_timeout", 32'(pc), 32'hFFFF_FFFF);
    step();
    pc_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      step();
      n++;
    end
    if (!instr_valid) chk(name, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    int n;
    pc_valid = 1'b0; pc_in = '0; flush = 1'b0; instr_ready = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pc_ready", 32'(pc_ready), 32'd1);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;
    step();

    // Single fetch with zero-wait memory: instr_valid three cycles after acceptance.
    mem_tab[16'h0010] = 16'hA5A5;
    offer(16'h0010, 10);
    #1;
    chk("t1_req", 32'(mem_req), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'h0010);
    step(); #1;
    chk("t1_not_yet", 32'(instr_valid), 32'd0);
    step(); #1;
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", 32'(instr), 32'hA5A5);
    chk("t1_pc", 32'(instr_pc), 32'h0010);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();

    // Fill the FIFO while decode stalls, then drain in order.
    for (int i = 0; i < 4; i++) offer(AW'(i), 20);
    repeat (3) step();
    pc_valid = 1'b1;
    pc_in    = 16'h0004;
    repeat (4) step();
    #1;
    chk("t2_full_ready", 32'(pc_ready), 32'd0);
    chk("t2_full_head", 32'(instr), 32'h1000);
    log_q.delete();
    instr_ready = 1'b1;
    offer(16'h0004, 20);
    n = 0;
    while (log_q.size() < 5 && n < 40) begin step(); n++; end
    chk("t2_drain_cnt", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < log_q.size()) chk("t2_order", 32'(log_q[i]), 32'h1000 + 32'(i));

    // Delayed grant: request and address held until granted.
    gnt_delay = 3;
    offer(16'h0040, 10);
    #1;
    n = 0;
    while (mem_req && n < 20) begin
      chk("t3_addr_hold", 32'(mem_addr), 32'h0040);
      n++;
      step(); #1;
    end
    chk("t3_req_cycles", 32'(n), 32'd4);
    gnt_delay = 0;
    repeat (4) step();

    // Flush during WAIT with two entries queued; the late response must vanish.
    instr_ready = 1'b0;
    offer(16'h0050, 10);
    offer(16'h0051, 10);
    repeat (4) step();
    mem_tab[16'h0030] = 16'hDEAD;
    rsp_delay = 1;
    offer(16'h0030, 10);
    n = 0;
    while (!mem_gnt && n < 10) begin step(); n++; end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("t4_flushed", 32'(instr_valid), 32'd0);
    chk("t4_rvalid_now", 32'(mem_rvalid), 32'd1);
    step(); #1;
    chk("t4_still_empty", 32'(instr_valid), 32'd0);
    rsp_delay = 0;
    offer(16'h0020, 10);
    wait_valid("t4_refetch_timeout", 10);
    #1;
    chk("t4_instr", 32'(instr), 32'h1020);
    chk("t4_pc", 32'(instr_pc), 32'h0020);
    chk("t4_no_dead", 32'(seen_dead), 32'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;

    // Push and pop on the same edge with one entry queued.
    offer(16'h0060, 10);
    wait_valid("t5_first_timeout", 10);
    offer(16'h0061, 10);
    n = 0;
    while (!mem_rvalid && n < 10) begin step(); n++; end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    #1;
    chk("t5_valid", 32'(instr_valid), 32'd1);
    chk("t5_instr", 32'(instr), 32'h1061);
    chk("t5_pc", 32'(instr_pc), 32'h0061);
    instr_ready = 1'b1;
    step(); #1;
    chk("t5_count_was_1", 32'(instr_valid), 32'd0);
    instr_ready = 1'b0;

    // Asynchronous reset mid-transaction, then a stray response in IDLE.
    offer(16'h0071, 10);
    wait_valid("t6_fill_timeout", 10);
    rsp_delay = 3;
    offer(16'h0070, 10);
    step();
    reset = 1'b1;
    #1;
    chk("t6_rst_req", 32'(mem_req), 32'd0);
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_ready", 32'(pc_ready), 32'd1);
    step();
    reset     = 1'b0;
    rsp_delay = 0;
    stray     = 1'b1;
    step();
    stray = 1'b0;
    step(); #1;
    chk("t6_stray_ignored", 32'(instr_valid), 32'd0);
    chk("t6_idle_req", 32'(mem_req), 32'd0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
